// File: rtl/addsub_checker_pkg.sv
// Shared types and defaults for the adder/subtractor response checker.
// Contents: checker FSM state enumeration, default operand and counter widths.
package addsub_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_CNT_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

endpackage

// File: rtl/addsub_checker_if.sv
// Bundles the stimulus/observation stream and the checker's status outputs.
// master: the side driving vectors and reading status (testbench / host).
// slave : the checker itself.
interface addsub_checker_if #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 16
);
  logic             start;
  logic [CNT_W-1:0] num_vec;
  logic             sample;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Add0_Sub1;
  logic [WIDTH-1:0] S;
  logic             Co;

  logic             busy;
  logic             done;
  logic             pass;
  logic [CNT_W-1:0] vec_cnt;
  logic [CNT_W-1:0] err_cnt;
  logic             fail_valid;
  logic [WIDTH-1:0] fail_A;
  logic [WIDTH-1:0] fail_B;
  logic [WIDTH-1:0] fail_S;
  logic             fail_op;
  logic             fail_Co;

  modport master (
    output start, num_vec, sample, A, B, Add0_Sub1, S, Co,
    input  busy, done, pass, vec_cnt, err_cnt,
           fail_valid, fail_A, fail_B, fail_S, fail_op, fail_Co
  );

  modport slave (
    input  start, num_vec, sample, A, B, Add0_Sub1, S, Co,
    output busy, done, pass, vec_cnt, err_cnt,
           fail_valid, fail_A, fail_B, fail_S, fail_op, fail_Co
  );
endinterface

// File: rtl/addsub_checker_ref.sv
// Combinational reference model of the adder/subtractor.
// Inputs : A, B (WIDTH), Add0_Sub1 (0 add, 1 subtract)
// Outputs: S_exp (WIDTH), Co_exp (on subtract, 1 = no borrow)
module addsub_ref #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Add0_Sub1,
  output logic [WIDTH-1:0] S_exp,
  output logic             Co_exp
);
  logic [WIDTH:0] sum;

  // Subtract as A + ~B + 1 so carry-out doubles as the not-borrow flag.
  always_comb begin
    sum = {1'b0, A} + {1'b0, B ^ {WIDTH{Add0_Sub1}}} + {{WIDTH{1'b0}}, Add0_Sub1};
  end

  assign S_exp  = sum[WIDTH-1:0];
  assign Co_exp = sum[WIDTH];
endmodule

// File: rtl/addsub_checker.sv
// Response checker for the 16-bit adder/subtractor.
// Ports: clk, rst_n (async active-low), bus (addsub_checker_if.slave):
//   start/num_vec arm a run; sample qualifies A, B, Add0_Sub1, S, Co;
//   busy/done/pass report run status; vec_cnt/err_cnt count vectors and
//   mismatches; fail_* hold the first mismatching vector.
// Pipeline: stage 1 registers the sampled vector, stage 2 compares it
// against addsub_ref one cycle later.
module addsub_checker
  import addsub_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  addsub_checker_if.slave  bus
);
  state_t state_q, state_d;

  logic [CNT_W-1:0] num_q, vec_q, err_q, vec_inc;
  logic             s1_valid, s1_op, s1_Co;
  logic [WIDTH-1:0] s1_A, s1_B, s1_S;
  logic             fail_valid_q, fail_op_q, fail_Co_q;
  logic [WIDTH-1:0] fail_A_q, fail_B_q, fail_S_q;
  logic [WIDTH-1:0] S_exp;
  logic             Co_exp;
  logic             start_ok, sample_ok, mismatch;

  assign start_ok  = bus.start && (state_q == IDLE || state_q == DONE);
  assign sample_ok = bus.sample && (state_q == RUN);
  assign vec_inc   = vec_q + CNT_W'(1);

  addsub_ref #(.WIDTH(WIDTH)) u_ref (
    .A         (s1_A),
    .B         (s1_B),
    .Add0_Sub1 (s1_op),
    .S_exp     (S_exp),
    .Co_exp    (Co_exp)
  );

  assign mismatch = s1_valid && ((s1_S != S_exp) || (s1_Co != Co_exp));

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: if (start_ok) state_d = (bus.num_vec == '0) ? DONE : RUN;
      RUN:        if (sample_ok && vec_inc == num_q) state_d = DRAIN;
      DRAIN:      state_d = DONE;
      default:    state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      num_q        <= '0;
      vec_q        <= '0;
      err_q        <= '0;
      s1_valid     <= 1'b0;
      s1_A         <= '0;
      s1_B         <= '0;
      s1_S         <= '0;
      s1_op        <= 1'b0;
      s1_Co        <= 1'b0;
      fail_valid_q <= 1'b0;
      fail_A_q     <= '0;
      fail_B_q     <= '0;
      fail_S_q     <= '0;
      fail_op_q    <= 1'b0;
      fail_Co_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      s1_valid <= sample_ok;
      if (sample_ok) begin
        s1_A  <= bus.A;
        s1_B  <= bus.B;
        s1_S  <= bus.S;
        s1_op <= bus.Add0_Sub1;
        s1_Co <= bus.Co;
        vec_q <= vec_inc;
      end
      if (start_ok) begin
        num_q        <= bus.num_vec;
        vec_q        <= '0;
        err_q        <= '0;
        fail_valid_q <= 1'b0;
        fail_A_q     <= '0;
        fail_B_q     <= '0;
        fail_S_q     <= '0;
        fail_op_q    <= 1'b0;
        fail_Co_q    <= 1'b0;
      end else if (mismatch) begin
        if (err_q != '1) err_q <= err_q + CNT_W'(1);
        if (!fail_valid_q) begin
          fail_valid_q <= 1'b1;
          fail_A_q     <= s1_A;
          fail_B_q     <= s1_B;
          fail_S_q     <= s1_S;
          fail_op_q    <= s1_op;
          fail_Co_q    <= s1_Co;
        end
      end
    end
  end

  assign bus.busy       = (state_q == RUN) || (state_q == DRAIN);
  assign bus.done       = (state_q == DONE);
  assign bus.pass       = (state_q == DONE) && (err_q == '0);
  assign bus.vec_cnt    = vec_q;
  assign bus.err_cnt    = err_q;
  assign bus.fail_valid = fail_valid_q;
  assign bus.fail_A     = fail_A_q;
  assign bus.fail_B     = fail_B_q;
  assign bus.fail_S     = fail_S_q;
  assign bus.fail_op    = fail_op_q;
  assign bus.fail_Co    = fail_Co_q;
endmodule
